// File: rtl/cache_bus_arbiter_pkg.sv
// Shared cache-bus types and arbiter FSM encodings used by the arbiter, its
// interface and its picker.
package cache_bus_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } cache_bus_req_t;

    typedef struct packed {
        logic        ready;
        logic        data_ok;
        logic        data_last;
        logic [31:0] rdata;
    } cache_bus_resp_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } cache_arb_state_e;

    // Plain-constant copies of cache_arb_state_e for legacy tools.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Bundle of upstream/downstream cache-bus signals around the arbiter.
// slave = arbiter view, master = environment (masters + downstream port) view.
interface cache_bus_arbiter_if #(
    parameter int PORT_NUM = 4
);
    import cache_bus_arbiter_pkg::*;

    cache_bus_req_t  [PORT_NUM-1:0] req_i;
    cache_bus_resp_t [PORT_NUM-1:0] resp_o;
    cache_bus_req_t                 req_o;
    cache_bus_resp_t                resp_i;
    logic            [PORT_NUM-1:0] grant_o;

    modport slave  (input  req_i, resp_i, output resp_o, req_o, grant_o);
    modport master (output req_i, resp_i, input  resp_o, req_o, grant_o);

endinterface

// File: rtl/cache_bus_arbiter_rr_picker.sv
// rr_picker: combinational one-hot priority picker; the search starts at
// i_base and wraps modulo N, so base 0 gives plain lowest-index priority.
module cache_bus_arbiter_rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_base,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_pos;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, i_base} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_pos = w_sum[IW-1:0];
            if (!w_found && i_req[w_pos]) begin
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// PORT_NUM-to-1 cache-bus arbiter, one transaction in flight, round-robin or
// fixed priority with starvation promotion. CACHE_ARB_PERF_EN adds perf counters.
module cache_bus_arbiter
    import cache_bus_arbiter_pkg::*;
#(
    parameter int PORT_NUM = 4,
    parameter int RR_MODE  = 1,
    parameter int MAX_WAIT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    cache_bus_arbiter_if.slave bus_if
`ifdef CACHE_ARB_PERF_EN
    ,
    output logic [PORT_NUM-1:0][31:0] perf_grant_o,
    output logic [PORT_NUM-1:0][31:0] perf_wait_o
`endif
);
    localparam int IW = $clog2(PORT_NUM);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [1:0]          r_state;
    logic [PORT_NUM-1:0] r_grant;
    logic [IW-1:0]       r_owner;
    logic [IW-1:0]       r_last_owner;

    logic [PORT_NUM-1:0] w_valid;
    logic [PORT_NUM-1:0] w_starved;
    logic [PORT_NUM-1:0] w_pick_req;
    logic [PORT_NUM-1:0] w_pick_gnt;
    logic [IW-1:0]       w_pick_idx;
    logic [IW-1:0]       w_base;
    logic                w_idle;
    logic                w_done;

    assign w_idle = (r_state == ST_IDLE);
    assign w_done = bus_if.resp_i.data_ok && bus_if.resp_i.data_last &&
                    (((r_state == ST_ADDR) && bus_if.resp_i.ready) || (r_state == ST_DATA));

    // Starved ports (fixed mode only) pre-empt everyone; ties go to the lowest index.
    assign w_pick_req = ((RR_MODE == 0) && (|w_starved)) ? w_starved : w_valid;
    assign w_base     = (RR_MODE == 0) ? '0 :
                        (r_last_owner == IW'(PORT_NUM - 1)) ? '0 : r_last_owner + IW'(1);

    cache_bus_arbiter_rr_picker #(
        .N  (PORT_NUM),
        .IW (IW)
    ) u_picker (
        .i_req  (w_pick_req),
        .i_base (w_base),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= IW'(PORT_NUM - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_valid) begin
                        r_state <= ST_ADDR;
                        r_grant <= w_pick_gnt;
                        r_owner <= w_pick_idx;
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (w_done) begin
                        r_state      <= ST_IDLE;
                        r_grant      <= '0;
                        r_last_owner <= r_owner;
                    end else if (bus_if.resp_i.ready) begin
                        r_state <= ST_DATA;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus_if.grant_o = r_grant;
    assign bus_if.req_o   = (|r_grant) ? bus_if.req_i[r_owner] : '0;

    generate
        for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_port
            logic [CW-1:0] r_wait;

            assign w_valid[gi]        = bus_if.req_i[gi].valid;
            assign w_starved[gi]      = w_valid[gi] && (r_wait == CW'(MAX_WAIT));
            assign bus_if.resp_o[gi]  = r_grant[gi] ? bus_if.resp_i : '0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wait <= '0;
                end else if (!w_valid[gi] || r_grant[gi] || (w_idle && w_pick_gnt[gi])) begin
                    r_wait <= '0;
                end else if (r_wait != CW'(MAX_WAIT)) begin
                    r_wait <= r_wait + CW'(1);
                end
            end

`ifdef CACHE_ARB_PERF_EN
            logic [31:0] r_perf_grant;
            logic [31:0] r_perf_wait;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_perf_grant <= '0;
                    r_perf_wait  <= '0;
                end else begin
                    if (w_done && r_grant[gi]) begin
                        r_perf_grant <= r_perf_grant + 32'd1;
                    end
                    if (w_valid[gi] && !r_grant[gi]) begin
                        r_perf_wait <= r_perf_wait + 32'd1;
                    end
                end
            end

            assign perf_grant_o[gi] = r_perf_grant;
            assign perf_wait_o[gi]  = r_perf_wait;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Scoreboard bench: dut_a is round-robin, dut_b fixed priority with MAX_WAIT=4.
module tb_cache_bus_arbiter;
    import cache_bus_arbiter_pkg::*;

    typedef struct {
        logic [3:0]  grant;
        logic [31:0] addr;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   rdy_a = 1, last_a = 1, cnt_a = 0;
    int   cnt_b = 0;
    logic [3:0] prev_ga, prev_gb;

    cache_bus_arbiter_if #(.PORT_NUM(4)) ifa ();
    cache_bus_arbiter_if #(.PORT_NUM(4)) ifb ();

`ifdef CACHE_ARB_PERF_EN
    logic [3:0][31:0] perf_grant_a, perf_wait_a, perf_grant_b, perf_wait_b;
`endif

    cache_bus_arbiter #(.PORT_NUM(4), .RR_MODE(1), .MAX_WAIT(64)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (ifa)
`ifdef CACHE_ARB_PERF_EN
        ,
        .perf_grant_o (perf_grant_a),
        .perf_wait_o  (perf_wait_a)
`endif
    );

    cache_bus_arbiter #(.PORT_NUM(4), .RR_MODE(0), .MAX_WAIT(4)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (ifb)
`ifdef CACHE_ARB_PERF_EN
        ,
        .perf_grant_o (perf_grant_b),
        .perf_wait_o  (perf_wait_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] addr_of(input int id, input int k);
        return ((id == 0) ? 32'h1000_0000 : 32'h2000_0000) + 32'(k) * 32'h100;
    endfunction

    // Downstream slave model: beat counter starts at 1 in the first granted cycle.
    function automatic cache_bus_resp_t mk_resp(input int cnt, input int rdy, input int last,
                                                input logic [31:0] addr);
        cache_bus_resp_t r;
        r = '0;
        if (cnt == rdy) r.ready = 1'b1;
        if (cnt == last) begin
            r.data_ok   = 1'b1;
            r.data_last = 1'b1;
        end else if (cnt > rdy && cnt < last) begin
            r.data_ok = 1'b1;
        end
        r.rdata = addr ^ 32'(cnt);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input int port, input int c);
        exp_t e;
        e.grant = 4'(1 << port);
        e.addr  = addr_of(id, port);
        e.cyc   = c;
        if (id == 0) qa.push_back(e);
        else         qb.push_back(e);
    endtask

    task automatic check_grant(input int id, input logic [3:0] g, input logic v,
                               input logic [31:0] a);
        exp_t e;
        int   n;
        checks++;
        n = (id == 0) ? qa.size() : qb.size();
        if (n == 0) begin
            errors++;
            $display("FAIL unexpected_grant dut%0d: got grant=%b cycle %0d, required no grant",
                     id, g, cyc);
        end else begin
            if (id == 0) e = qa.pop_front();
            else         e = qb.pop_front();
            if (g !== e.grant || v !== 1'b1 || a !== e.addr || cyc != e.cyc) begin
                errors++;
                $display("FAIL grant_seq dut%0d: got grant=%b valid=%b addr=%h cycle %0d, required grant=%b valid=1 addr=%h cycle %0d",
                         id, g, v, a, cyc, e.grant, e.addr, e.cyc);
            end else begin
                $display("txn dut%0d: grant=%b addr=%h cycle %0d", id, g, a, cyc);
            end
        end
    endtask

    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_valid(input int id, input logic [3:0] m);
        for (int k = 0; k < 4; k++) begin
            if (id == 0) ifa.req_i[k].valid = m[k];
            else         ifb.req_i[k].valid = m[k];
        end
    endtask

    // Responders: dut_a is scripted through rdy_a/last_a, dut_b is always single-beat.
    initial begin
        ifa.resp_i = '0;
        ifb.resp_i = '0;
        forever begin
            @(negedge clk);
            if (ifa.req_o.valid) begin
                cnt_a++;
                ifa.resp_i = mk_resp(cnt_a, rdy_a, last_a, ifa.req_o.addr);
            end else begin
                cnt_a      = 0;
                ifa.resp_i = '0;
            end
            if (ifb.req_o.valid) begin
                cnt_b++;
                ifb.resp_i = mk_resp(cnt_b, 1, 1, ifb.req_o.addr);
            end else begin
                cnt_b      = 0;
                ifb.resp_i = '0;
            end
        end
    end

    // Monitor: every new grant is checked against the head of its scoreboard queue.
    initial begin
        prev_ga = '0;
        prev_gb = '0;
        forever begin
            @(negedge clk);
            if (ifa.grant_o != 4'd0 && prev_ga == 4'd0)
                check_grant(0, ifa.grant_o, ifa.req_o.valid, ifa.req_o.addr);
            if (ifb.grant_o != 4'd0 && prev_gb == 4'd0)
                check_grant(1, ifb.grant_o, ifb.req_o.valid, ifb.req_o.addr);
            prev_ga = ifa.grant_o;
            prev_gb = ifb.grant_o;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not end by cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ifa.req_i[k]       = '0;
            ifa.req_i[k].addr  = addr_of(0, k);
            ifa.req_i[k].wdata = 32'hD000_0000 + 32'(k);
            ifb.req_i[k]       = '0;
            ifb.req_i[k].addr  = addr_of(1, k);
            ifb.req_i[k].wdata = 32'hE000_0000 + 32'(k);
        end

        // Reset state
        at(2);
        @(negedge clk); #1;
        chk("reset_grant_a", 64'(ifa.grant_o), 64'd0);
        chk("reset_grant_b", 64'(ifb.grant_o), 64'd0);
        chk("reset_req_o_zero_a", 64'(|ifa.req_o), 64'd0);
        chk("reset_resp_o_zero_a", 64'(|ifa.resp_o), 64'd0);
`ifdef CACHE_ARB_PERF_EN
        chk("reset_perf_a", 64'(|{perf_grant_a, perf_wait_a}), 64'd0);
`endif
        at(3);
        rst_n = 1'b1;

        // Round-robin, all four valid, single-beat: 0,1,2,3,0 every other cycle
        at(5);
        rdy_a = 1; last_a = 1;
        set_valid(0, 4'b1111);
        push(0, 0, 6); push(0, 1, 8); push(0, 2, 10); push(0, 3, 12); push(0, 0, 14);
        at(15);
        set_valid(0, 4'b0000);

        // Port 2 alone, 4-beat read: ready at cycle 3, last at cycle 7 of the grant
        at(18);
        rdy_a = 3; last_a = 7;
        set_valid(0, 4'b0100);
        push(0, 2, 19);
        for (int c = 19; c <= 26; c++) begin
            at(c);
            if (c == 26) set_valid(0, 4'b0000);
            @(negedge clk); #1;
            if (c <= 25) begin
                chk("burst_grant_held", 64'(ifa.grant_o), 64'h4);
                chk("burst_nonowner_resp_zero",
                    64'(|{ifa.resp_o[0], ifa.resp_o[1], ifa.resp_o[3]}), 64'd0);
            end else begin
                chk("burst_grant_released", 64'(ifa.grant_o), 64'd0);
            end
            if (c == 25) chk("burst_last_beat_routed", 64'(ifa.resp_o[2].data_last), 64'd1);
        end

        // Fixed priority, port 0 hogging, port 3 promoted once its counter hits 4
        at(30);
        set_valid(1, 4'b1001);
        push(1, 0, 31); push(1, 0, 33); push(1, 3, 35); push(1, 0, 37);
        at(36);
        set_valid(1, 4'b0001);
        at(38);
        set_valid(1, 4'b0000);

        // Async reset in the middle of a data phase
        at(42);
        rdy_a = 2; last_a = 20;
        set_valid(0, 4'b0010);
        push(0, 1, 43);
        at(46);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_grant", 64'(ifa.grant_o), 64'd0);
        chk("async_reset_req_valid", 64'(ifa.req_o.valid), 64'd0);
        set_valid(0, 4'b1111);
        rdy_a = 1; last_a = 1;
        at(48);
        rst_n = 1'b1;
        push(0, 0, 49);
        at(50);
        set_valid(0, 4'b0000);

        // Fresh reset, then three port-1 transactions behind one port-0 transaction
        at(52);
        rst_n = 1'b0;
        at(54);
        rst_n = 1'b1;
        at(56);
        set_valid(0, 4'b0011);
        push(0, 0, 57); push(0, 1, 59); push(0, 1, 61); push(0, 1, 63);
        at(58);
        set_valid(0, 4'b0010);
        at(64);
        set_valid(0, 4'b0000);
        at(66);
        @(negedge clk); #1;
        chk("idle_after_perf_run", 64'(ifa.grant_o), 64'd0);
`ifdef CACHE_ARB_PERF_EN
        chk("perf_grant_port1", 64'(perf_grant_a[1]), 64'd3);
        chk("perf_wait_port1", 64'(perf_wait_a[1]), 64'd5);
        chk("perf_grant_port0", 64'(perf_grant_a[0]), 64'd1);
`endif

        at(70);
        chk("scoreboard_drained_a", 64'(qa.size()), 64'd0);
        chk("scoreboard_drained_b", 64'(qb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
